// File: rtl/solo_squash_input_conditioner_pkg.sv
// Shared constants for the solo_squash input front end: GPIO map and button channel indices.
package solo_squash_input_conditioner_pkg;

  // Caravel GPIO map used by the game (inputs 8..12, outputs 13..20)
  localparam int unsigned GpioExtResetN = 8;
  localparam int unsigned GpioPauseN    = 9;
  localparam int unsigned GpioNewGameN  = 10;
  localparam int unsigned GpioUpKeyN    = 11;
  localparam int unsigned GpioDownKeyN  = 12;
  localparam int unsigned GpioOutFirst  = 13;
  localparam int unsigned GpioOutLast   = 20;

  localparam int unsigned NumButtons = 5;

  typedef enum logic [2:0] {
    BtnExtReset,
    BtnPause,
    BtnNewGame,
    BtnUp,
    BtnDown
  } button_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/solo_squash_debounce.sv
// Single-bit synchroniser plus debouncer for an active-low button.
// Emits the accepted (stable) level and a one-cycle strobe on each accepted press.
module solo_squash_debounce
  import solo_squash_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_io_valid,
  input  logic i_raw_n,
  output logic o_stable_n,
  output logic o_press
);

  localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_stable_n;
  logic                   r_press;
  logic                   w_din;
  logic                   w_sync;
  logic                   w_differ;
  logic                   w_accept;

  always_comb begin
    w_din    = i_io_valid ? i_raw_n : 1'b1;
    w_sync   = r_sync[SYNC_STAGES-1];
    w_differ = (w_sync != r_stable_n);
    w_accept = w_differ && (r_cnt == CntMax);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_din};
    end
  end

  // Dropping io_valid forces the released level at once so no events are generated by it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stable_n <= 1'b1;
      r_cnt      <= '0;
      r_press    <= 1'b0;
    end else if (!i_io_valid) begin
      r_stable_n <= 1'b1;
      r_cnt      <= '0;
      r_press    <= 1'b0;
    end else begin
      r_press <= w_accept && !w_sync;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable_n <= w_sync;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_stable_n = r_stable_n;
  assign o_press    = r_press;

endmodule

// File: rtl/solo_squash_input_conditioner.sv
// Conditions the raw active-low game buttons into clean active-high controls:
// held up/down levels, new-game pulse, pause toggle and a stretched game reset.
module solo_squash_input_conditioner
  import solo_squash_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned RESET_HOLD      = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_io_valid,
  input  logic i_ext_reset_n_raw,
  input  logic i_pause_n_raw,
  input  logic i_new_game_n_raw,
  input  logic i_up_key_n_raw,
  input  logic i_down_key_n_raw,
  output logic o_up,
  output logic o_down,
  output logic o_paused,
  output logic o_new_game,
  output logic o_game_reset
);

  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1);

  logic [NumButtons-1:0] w_raw_n;
  logic [NumButtons-1:0] w_stable_n;
  logic [NumButtons-1:0] w_press;
  logic                  w_up_held;
  logic                  w_down_held;
  logic                  w_reset_src;

  logic             r_up;
  logic             r_down;
  logic             r_paused;
  logic             r_new_game;
  logic             r_game_reset;
  logic [HoldW-1:0] r_hold;

  assign w_raw_n = {i_down_key_n_raw, i_up_key_n_raw, i_new_game_n_raw, i_pause_n_raw,
                    i_ext_reset_n_raw};

  for (genvar g = 0; g < NumButtons; g++) begin : g_btn
    solo_squash_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_io_valid(i_io_valid),
      .i_raw_n   (w_raw_n[g]),
      .o_stable_n(w_stable_n[g]),
      .o_press   (w_press[g])
    );
  end

  always_comb begin
    w_up_held   = !w_stable_n[BtnUp];
    w_down_held = !w_stable_n[BtnDown];
    w_reset_src = !i_io_valid || !w_stable_n[BtnExtReset];
  end

  // Opposing keys cancel; io_valid gating drops held levels the same cycle game_reset rises
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_new_game <= 1'b0;
      r_paused   <= 1'b0;
    end else begin
      r_up       <= i_io_valid && w_up_held && !w_down_held;
      r_down     <= i_io_valid && w_down_held && !w_up_held;
      r_new_game <= i_io_valid && w_press[BtnNewGame];
      r_paused   <= r_game_reset ? 1'b0 : (r_paused ^ w_press[BtnPause]);
    end
  end

  // Countdown reaches 0 after RESET_HOLD released cycles; game_reset drops on the next edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_game_reset <= 1'b1;
      r_hold       <= HoldW'(RESET_HOLD);
    end else if (w_reset_src) begin
      r_game_reset <= 1'b1;
      r_hold       <= HoldW'(RESET_HOLD);
    end else if (r_hold != '0) begin
      r_game_reset <= 1'b1;
      r_hold       <= r_hold - HoldW'(1);
    end else begin
      r_game_reset <= 1'b0;
    end
  end

  assign o_up         = r_up;
  assign o_down       = r_down;
  assign o_paused     = r_paused;
  assign o_new_game   = r_new_game;
  assign o_game_reset = r_game_reset;

endmodule

// File: tb/tb_solo_squash_input_conditioner.sv
// Directed bench for solo_squash_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_HOLD=3).
// Stimulus queues expected output vectors per cycle; a negedge monitor pops and compares them.
module tb_solo_squash_input_conditioner;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Debounce   = 4;
  localparam int unsigned Hold       = 3;

  typedef struct {
    int         cyc;
    logic [4:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, io_valid, ext_n, pause_n, ng_n, up_n, down_n;
  logic up, down, paused, new_game, game_reset;
  logic [4:0] outs;

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   flush  = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  solo_squash_input_conditioner #(
    .SYNC_STAGES    (SyncStages),
    .DEBOUNCE_CYCLES(Debounce),
    .RESET_HOLD     (Hold)
  ) u_dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_io_valid       (io_valid),
    .i_ext_reset_n_raw(ext_n),
    .i_pause_n_raw    (pause_n),
    .i_new_game_n_raw (ng_n),
    .i_up_key_n_raw   (up_n),
    .i_down_key_n_raw (down_n),
    .o_up             (up),
    .o_down           (down),
    .o_paused         (paused),
    .o_new_game       (new_game),
    .o_game_reset     (game_reset)
  );

  // Vector order: {game_reset, new_game, paused, down, up}
  assign outs = {game_reset, new_game, paused, down, up};

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc < cyc || (flush && q[i].cyc > cyc)) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: vector for cycle %0d never checked (now %0d)", q[i].name, q[i].cyc, cyc);
        q.delete(i);
      end else if (q[i].cyc == cyc) begin
        n_vec++;
        if (outs !== q[i].val) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %b, expected %b", q[i].name, cyc, outs, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_rng(input int c0, input int c1, input logic [4:0] v, input string nm);
    for (int c = c0; c <= c1; c++) q.push_back('{cyc: c, val: v, name: nm});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    reset_n  = 1'b0;
    io_valid = 1'b0;
    ext_n    = 1'b1;
    pause_n  = 1'b1;
    ng_n     = 1'b1;
    up_n     = 1'b1;
    down_n   = 1'b1;

    // Reset, then gated by io_valid, then RESET_HOLD countdown
    expect_rng(1, 3, 5'b10000, "reset_state");
    wait_until(3);
    reset_n = 1'b1;
    expect_rng(4, 5, 5'b10000, "io_gated");
    wait_until(5);
    t0 = cyc;
    io_valid = 1'b1;
    expect_rng(t0 + 1, t0 + 3, 5'b10000, "hold_count");
    expect_rng(t0 + 4, t0 + 8, 5'b00000, "reset_release");
    wait_until(t0 + 8);

    // Clean up press and release: 7-cycle latency both ways
    t0 = cyc;
    up_n = 1'b0;
    expect_rng(t0 + 1, t0 + 6, 5'b00000, "up_press_lat");
    expect_rng(t0 + 7, t0 + 10, 5'b00001, "up_held");
    wait_until(t0 + 10);
    t0 = cyc;
    up_n = 1'b1;
    expect_rng(t0 + 1, t0 + 6, 5'b00001, "up_release_lat");
    expect_rng(t0 + 7, t0 + 9, 5'b00000, "up_released");
    wait_until(t0 + 9);

    // Glitchy up: 3 low, 1 high, 3 low never reaches the debounce count
    t0 = cyc;
    up_n = 1'b0;
    expect_rng(t0 + 1, t0 + 16, 5'b00000, "glitch_reject");
    wait_until(t0 + 3);
    up_n = 1'b1;
    wait_until(t0 + 4);
    up_n = 1'b0;
    wait_until(t0 + 7);
    up_n = 1'b1;
    wait_until(t0 + 16);

    // New game held 20 cycles: one pulse only
    t0 = cyc;
    ng_n = 1'b0;
    expect_rng(t0 + 1, t0 + 6, 5'b00000, "ng_lat");
    expect_rng(t0 + 7, t0 + 7, 5'b01000, "ng_pulse");
    expect_rng(t0 + 8, t0 + 30, 5'b00000, "ng_no_repeat");
    wait_until(t0 + 20);
    ng_n = 1'b1;
    wait_until(t0 + 30);

    // Two clean pause presses
    t0 = cyc;
    pause_n = 1'b0;
    expect_rng(t0 + 1, t0 + 6, 5'b00000, "pause_lat");
    expect_rng(t0 + 7, t0 + 22, 5'b00100, "paused_on");
    expect_rng(t0 + 23, t0 + 31, 5'b00000, "paused_off");
    wait_until(t0 + 8);
    pause_n = 1'b1;
    wait_until(t0 + 16);
    pause_n = 1'b0;
    wait_until(t0 + 24);
    pause_n = 1'b1;
    wait_until(t0 + 31);

    // Up and down together cancel; releasing down lets up through
    t0 = cyc;
    up_n   = 1'b0;
    down_n = 1'b0;
    expect_rng(t0 + 1, t0 + 18, 5'b00000, "updown_cancel");
    expect_rng(t0 + 19, t0 + 26, 5'b00001, "up_after_down");
    expect_rng(t0 + 27, t0 + 28, 5'b00000, "updown_idle");
    wait_until(t0 + 12);
    down_n = 1'b1;
    wait_until(t0 + 20);
    up_n = 1'b1;
    wait_until(t0 + 28);

    // Paused, then ext reset: reset rises, pause clears; io_valid blip reloads the countdown
    t0 = cyc;
    pause_n = 1'b0;
    expect_rng(t0 + 1, t0 + 6, 5'b00000, "ext_pre");
    expect_rng(t0 + 7, t0 + 14, 5'b00100, "ext_paused");
    expect_rng(t0 + 15, t0 + 15, 5'b10100, "ext_reset_rise");
    expect_rng(t0 + 16, t0 + 31, 5'b10000, "ext_pause_clear");
    expect_rng(t0 + 32, t0 + 34, 5'b00000, "ext_hold_reload");
    wait_until(t0 + 8);
    ext_n = 1'b0;
    wait_until(t0 + 9);
    pause_n = 1'b1;
    wait_until(t0 + 20);
    ext_n = 1'b1;
    wait_until(t0 + 27);
    io_valid = 1'b0;
    wait_until(t0 + 28);
    io_valid = 1'b1;
    wait_until(t0 + 34);

    // io_valid dropped while up held: up clears and game_reset rises next cycle
    t0 = cyc;
    up_n = 1'b0;
    expect_rng(t0 + 1, t0 + 6, 5'b00000, "iov_pre");
    expect_rng(t0 + 7, t0 + 9, 5'b00001, "iov_up");
    expect_rng(t0 + 10, t0 + 15, 5'b10000, "iov_drop");
    expect_rng(t0 + 16, t0 + 18, 5'b00000, "iov_recover");
    expect_rng(t0 + 19, t0 + 26, 5'b00001, "iov_up_again");
    expect_rng(t0 + 27, t0 + 28, 5'b00000, "iov_idle");
    wait_until(t0 + 9);
    io_valid = 1'b0;
    wait_until(t0 + 12);
    io_valid = 1'b1;
    wait_until(t0 + 20);
    up_n = 1'b1;
    wait_until(t0 + 28);

    // Asynchronous reset mid-debounce of down
    t0 = cyc;
    up_n = 1'b0;
    expect_rng(t0 + 1, t0 + 6, 5'b00000, "arst_pre");
    expect_rng(t0 + 7, t0 + 9, 5'b00001, "arst_up");
    expect_rng(t0 + 10, t0 + 15, 5'b10000, "arst_values");
    expect_rng(t0 + 16, t0 + 18, 5'b00000, "arst_release");
    wait_until(t0 + 8);
    down_n = 1'b0;
    wait_until(t0 + 10);
    reset_n = 1'b0;
    up_n    = 1'b1;
    down_n  = 1'b1;
    wait_until(t0 + 12);
    reset_n = 1'b1;
    wait_until(t0 + 18);

    tick();
    flush = 1'b1;
    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
